// File: rtl/shift_seq_ctrl.sv
// Multi-cycle right shifter: applies up to STEP_MAX bits per cycle and reports {N,Z,C,V} on a DONE pulse.
// SHIFT_ARITH_EN enables sign-fill when arith=1; without it every shift is logical.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | applying one step per cycle
//   DONE  | one-cycle done pulse, result/flags valid
module shift_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int STEP_MAX = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [4:0]       s_value,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // per-cycle step is clamped to what the 5-bit shift amount can express
  localparam logic [4:0] STEP_L = (STEP_MAX > 31) ? 5'd31 :
                                  (STEP_MAX < 1)  ? 5'd1  : 5'(STEP_MAX);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       rem_q, rem_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [4:0]       step;
  logic [WIDTH-1:0] shifted;

`ifdef SHIFT_ARITH_EN
  logic mode_q, mode_d;
`else
  logic unused_arith;
  assign unused_arith = arith;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    result_d = result_q;
    flags_d  = flags_q;
    step     = 5'd0;
    shifted  = acc_q;
`ifdef SHIFT_ARITH_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = din;
          rem_d   = s_value;
          carry_d = 1'b0;
`ifdef SHIFT_ARITH_EN
          mode_d  = arith;
`endif
          if (s_value == 5'd0) begin
            state_d  = DONE;
            result_d = din;
            flags_d  = {din[WIDTH-1], (din == '0), 1'b0, 1'b0};
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        step = (rem_q > STEP_L) ? STEP_L : rem_q;
`ifdef SHIFT_ARITH_EN
        if (mode_q) shifted = $unsigned($signed(acc_q) >>> step);
        else        shifted = acc_q >> step;
`else
        shifted = acc_q >> step;
`endif
        carry_d = acc_q[step - 5'd1];
        acc_d   = shifted;
        rem_d   = rem_q - step;
        if (rem_d == 5'd0) begin
          state_d  = DONE;
          result_d = shifted;
          flags_d  = {shifted[WIDTH-1], (shifted == '0), carry_d, 1'b0};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= 5'd0;
      carry_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

`ifdef SHIFT_ARITH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`endif

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL provide parameter STEP_MAX, default 5, maximum shift applied per cycle.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL port clk  input  1  rising-edge clock.
REQ-005 SHALL port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL port start  input  1  request; accepted only in a cycle where busy=0.
REQ-007 SHALL port din  input  WIDTH  operand, sampled on acceptance.
REQ-008 SHALL port s_value  input  5  total right-shift amount 0..31, sampled on acceptance.
REQ-009 SHALL port arith  input  1  1=arithmetic (sign-fill) shift, sampled on acceptance.
REQ-010 SHALL port busy  output  1  high in SHIFT and DONE states.
REQ-011 SHALL port done  output  1  one-cycle pulse; result and flags valid.
REQ-012 SHALL port result  output  WIDTH  registered shifted value.
REQ-013 SHALL port flags  output  4  {N,Z,C,V}, registered.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: on start=1, SHALL load acc=din, rem=s_value, carry=0, mode=arith; go to SHIFT if s_value!=0, else DONE.
REQ-016 SHIFT: each cycle, step=min(rem,STEP_MAX); carry=acc[step-1]; acc=acc>>step with fill per mode; rem=rem-step.
REQ-017 SHIFT SHALL go to DONE on the edge where rem becomes 0, else remain in SHIFT.
REQ-018 DONE SHALL last exactly one cycle, then go to IDLE; done=1 only in DONE.
REQ-019 On entry to DONE, SHALL register result=acc, N=acc[WIDTH-1], Z=(acc==0), C=carry, V=0.
REQ-020 Latency: done SHALL be high in the cycle after edge k+ceil(s_value/STEP_MAX)+1, where k is the acceptance edge; s_value=0 gives k+1.
REQ-021 result and flags SHALL hold their values until the next DONE entry.
REQ-022 start while busy=1 SHALL be ignored without affecting the operation in progress; start in DONE SHALL also be ignored.
REQ-023 Changes to din, s_value and arith after acceptance SHALL NOT affect the operation.
REQ-024 C SHALL be 0 when s_value=0.
REQ-025 C SHALL be the last bit shifted out overall, i.e. din[s_value-1].

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, result=0, flags=0, and acc/rem/carry=0, regardless of clk.
REQ-027 Reset mid-SHIFT SHALL abort the operation without producing a done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-028 Macro SHIFT_ARITH_EN defined: arith=1 SHALL fill vacated MSBs with din[WIDTH-1]; arith=0 fills zeros.
REQ-029 Macro SHIFT_ARITH_EN undefined: arith port SHALL still exist but is ignored; all shifts are logical (zero fill).

Verification
REQ-030 din=0x80000001, s_value=12, arith=0, start -> 3 SHIFT cycles (steps 5,5,2); done at k+4; result=0x00080000; flags N0 Z0 C0 V0.
REQ-031 din=0x0000001F, s_value=5 -> done at k+2; result=0x00000000; flags N0 Z1 C1 V0.
REQ-032 din=0x80000000, s_value=0 -> done at k+1; result=0x80000000; flags N1 Z0 C0 V0.
REQ-033 din=0xFFFFFFFF, s_value=31, arith=1 -> 7 SHIFT cycles; done at k+8; result=0x00000001, C1 without macro; result=0xFFFFFFFF, N1 C1 with SHIFT_ARITH_EN.
REQ-034 Accept din=0x00000100, s_value=8, then pulse start with din=0xDEADBEEF while busy -> single done; result=0x00000001, C0; second request is dropped.
REQ-035 Assert rst during the second SHIFT cycle of a s_value=20 operation -> busy=0, result=0, flags=0 immediately; no done pulse; a new start after release completes normally.
